// File: rtl/main_module.sv
// main_module: streaming multiply-accumulate (correlation) engine for the OCR datapath.
// Optional feature macro ONE_BY_N_EN adds a reciprocal ROM and an output stage presenting the window mean.
module main_module #(
    parameter int DW = 8,
    parameter int AW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] Xn,
    input  logic [DW-1:0] Cn,
    input  logic [DW-1:0] IP_COUN,
    output logic [AW-1:0] OP_AR
);

    // Stage 1: input capture
    logic [DW-1:0]   px_q;
    logic [DW-1:0]   pc_q;
    logic [DW-1:0]   pcnt_q;

    // Stage 2: multiply-accumulate
    logic [2*DW-1:0] prod;
    logic [AW-1:0]   acc_d;
    logic [AW-1:0]   acc_q;

    always_comb begin
        prod  = px_q * pc_q;
        // A zero index opens a new window; any other value keeps accumulating, wrapping silently.
        acc_d = (pcnt_q == '0) ? AW'(prod) : acc_q + AW'(prod);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            px_q   <= '0;
            pc_q   <= '0;
            pcnt_q <= '0;
            acc_q  <= '0;
        end else begin
            px_q   <= Xn;
            pc_q   <= Cn;
            pcnt_q <= IP_COUN;
            acc_q  <= acc_d;
        end
    end

`ifdef ONE_BY_N_EN
    localparam int RW = 17;

    // acnt_q is the window index of the value currently held in acc_q.
    logic [DW-1:0]    acnt_q;
    logic [RW-1:0]    recip [2**DW];
    logic [AW+RW-1:0] scaled;
    logic [AW-1:0]    out_d;
    logic [AW-1:0]    out_q;

    // Constant table: recip[n] = floor(65536/(n+1)), so recip[0] = 65536 needs the 17th bit.
    for (genvar n = 0; n < 2**DW; n++) begin : g_recip
        assign recip[n] = RW'(65536 / (n + 1));
    end

    always_comb begin
        scaled = (AW+RW)'(acc_q) * (AW+RW)'(recip[acnt_q]);
        out_d  = AW'(scaled >> 16);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acnt_q <= '0;
            out_q  <= '0;
        end else begin
            acnt_q <= pcnt_q;
            out_q  <= out_d;
        end
    end

    assign OP_AR = out_q;
`else
    assign OP_AR = acc_q;
`endif

endmodule

// File: tb/tb_main_module.sv
// Scoreboard testbench for main_module: the driver pushes expected OP_AR values, a negedge monitor pops and compares.
// Covers reset, window start, held inputs, mid-window reset, ramp and 32-bit wrap; honours ONE_BY_N_EN.
module tb_main_module;

`ifdef ONE_BY_N_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  Xn = 8'd255;
    logic [7:0]  Cn = 8'd255;
    logic [7:0]  IP_COUN = 8'd7;
    logic [31:0] OP_AR;

    main_module dut (
        .CLK     (CLK),
        .RST     (RST),
        .Xn      (Xn),
        .Cn      (Cn),
        .IP_COUN (IP_COUN),
        .OP_AR   (OP_AR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int phase    = 0;

    logic [31:0] exp_q [$];
    int          due_q [$];
    int          tag_q [$];

    // Reference model state
    logic [31:0] m_acc = '0;

    function automatic string pname(input int p);
        case (p)
            0: return "reset_hold";
            1: return "window_start";
            2: return "held_inputs";
            3: return "async_reset";
            4: return "post_reset";
            5: return "ramp";
            6: return "wrap";
            default: return "other";
        endcase
    endfunction

    task automatic push_exp(input logic [31:0] e, input int due);
        exp_q.push_back(e);
        due_q.push_back(due);
        tag_q.push_back(phase);
    endtask

    // Apply one sample now and record its expected response LAT edges later.
    task automatic apply(input logic [7:0] x, input logic [7:0] c, input logic [7:0] n, input bit chk);
        logic [31:0] prod;
        logic [31:0] e;
        Xn      = x;
        Cn      = c;
        IP_COUN = n;
        prod  = 32'(x) * 32'(c);
        m_acc = (n == 8'd0) ? prod : m_acc + prod;
`ifdef ONE_BY_N_EN
        e = 32'((64'(m_acc) * 64'(65536 / (int'(n) + 1))) >> 16);
`else
        e = m_acc;
`endif
        if (chk) push_exp(e, cyc + LAT);
    endtask

    task automatic drive(input logic [7:0] x, input logic [7:0] c, input logic [7:0] n, input bit chk);
        @(posedge CLK);
        #1;
        apply(x, c, n, chk);
    endtask

    // Monitor: OP_AR is always presented, so compare whenever an expectation falls due.
    always @(negedge CLK) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            logic [31:0] e;
            int          t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            void'(due_q.pop_front());
            checks++;
            if (OP_AR !== e) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%0d expected=%0d", pname(t), cyc, OP_AR, e);
            end
        end
    end

    initial begin
        int wait_cycles;

        // Reset held with busy inputs: output must stay 0.
        phase = 0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            push_exp(32'd0, cyc);
        end

        // Release and open a window on the very first processed cycle.
        phase = 1;
        RST   = 1'b1;
        m_acc = '0;
        apply(8'd3, 8'd4, 8'd0, 1'b1);
        drive(8'd5, 8'd6, 8'd1, 1'b1);

        // Held inputs accumulate once per clock; a zero index restarts.
        phase = 2;
        drive(8'd2, 8'd5, 8'd0, 1'b1);
        repeat (4) drive(8'd2, 8'd2, 8'd3, 1'b1);
        drive(8'd1, 8'd9, 8'd0, 1'b1);
        drive(8'd7, 8'd7, 8'd0, 1'b1);
        drive(8'd7, 8'd7, 8'd1, 1'b1);
        drive(8'd0, 8'd0, 8'd2, 1'b1);

        // Asynchronous reset between edges clears OP_AR before the next edge.
        phase = 3;
        @(posedge CLK);
        #3;
        RST = 1'b0;
        exp_q.delete();
        due_q.delete();
        tag_q.delete();
        m_acc = '0;
        push_exp(32'd0, cyc);
        @(posedge CLK);
        #1;
        push_exp(32'd0, cyc);

        // After release, a nonzero index accumulates onto an empty sum.
        phase = 4;
        RST   = 1'b1;
        apply(8'd3, 8'd3, 8'd5, 1'b1);
        drive(8'd4, 8'd4, 8'd9, 1'b1);
        drive(8'd3, 8'd4, 8'd0, 1'b1);
        drive(8'd5, 8'd6, 8'd1, 1'b1);

        // Ramp: Xn = Cn = IP_COUN = v, two clocks per value.
        phase = 5;
        for (int v = 0; v < 256; v++) begin
            drive(8'(v), 8'(v), 8'(v), 1'b1);
            drive(8'(v), 8'(v), 8'(v), 1'b1);
        end

        // Window held open past 2^32: 66052 * 65025 mod 2^32 = 64004.
        phase = 6;
        drive(8'd255, 8'd255, 8'd0, 1'b1);
        for (int i = 0; i < 66050; i++) drive(8'd255, 8'd255, 8'd1, 1'b0);
        drive(8'd255, 8'd255, 8'd1, 1'b1);
        drive(8'd1, 8'd1, 8'd0, 1'b1);

        // Drain with a bounded wait.
        wait_cycles = 0;
        while (due_q.size() > 0 && wait_cycles < LAT + 8) begin
            @(posedge CLK);
            wait_cycles++;
        end
        @(negedge CLK);
        #1;
        if (due_q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", due_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
